mem_wb_writeback: RTL and testbench

//   MEM/WB pipeline latch and writeback driver: the write side of the register file.

---
 rtl/mips_pkg.sv | 9 +
 rtl/mem_wb_latch.sv | 28 ++
 rtl/mem_wb_writeback.sv | 82 ++++++++
 tb/tb_mem_wb_writeback.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath/register widths and the hardwired $zero index.
// No logic; no latency.
// No flow control.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/mem_wb_latch.sv
// Generic pipeline register with a separate valid bit; flush kills valid, stall holds.
// Latency: 1 cycle.
// Backpressure: stall freezes every field; flush overrides stall and clears valid only.
module mem_wb_latch #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_dat,
    output logic         valid_q,
    output logic [W-1:0] dat_q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dat_q   <= '0;
        end else if (flush) begin
            // Payload is left as-is; only valid matters once the slot is killed.
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= in_valid;
            dat_q   <= in_dat;
        end
    end
endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB latch plus register-file write port, ID bypass selects and retired-instruction counter.
// Latency: 1 cycle from MEM inputs to register-file outputs.
// Backpressure: stall holds the latch (the write simply repeats); flush kills the latched slot.
module mem_wb_writeback
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = mips_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic [REG_AW-1:0] rd,
    output logic [DATA_W-1:0] writedata,
    output logic              regwrite,
    output logic              wb_valid,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [CNT_W-1:0]  retired_count
);
    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data;
    } wb_fields_t;

    wb_fields_t        in_fields;
    wb_fields_t        wb_q;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        in_fields            = '0;
        in_fields.regwrite   = in_regwrite;
        in_fields.memtoreg   = in_memtoreg;
        in_fields.rd         = in_rd;
        in_fields.alu_result = in_alu_result;
        in_fields.read_data  = in_read_data;
    end

    mem_wb_latch #(.W($bits(wb_fields_t))) u_latch (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .in_valid (in_valid),
        .in_dat   (in_fields),
        .valid_q  (valid_q),
        .dat_q    (wb_q)
    );

    // All outputs come from the latch so the register file sees a clean registered write.
    assign writedata = wb_q.memtoreg ? wb_q.read_data : wb_q.alu_result;
    assign rd        = wb_q.rd;
    assign regwrite  = valid_q & wb_q.regwrite & (wb_q.rd != REG_AW'(ZERO_REG));
    assign wb_valid  = valid_q;
    assign fwd_a     = regwrite & (id_rs == wb_q.rd);
    assign fwd_b     = regwrite & (id_rt == wb_q.rd);

    // An instruction retires when it leaves the latch; a same-edge flush does not undo that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (valid_q && !stall) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign retired_count = cnt_q;
endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed-vector bench for mem_wb_writeback: a driver queues expected outputs per issued
// cycle and a negedge monitor pops and compares them.
module tb_mem_wb_writeback;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, in_regwrite = 1'b0, in_memtoreg = 1'b0;
    logic [4:0]  in_rd = '0, id_rs = '0, id_rt = '0;
    logic [31:0] in_alu_result = '0, in_read_data = '0;
    logic [4:0]  rd;
    logic [31:0] writedata;
    logic        regwrite, wb_valid, fwd_a, fwd_b;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        v;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        rw;
        logic        fa;
        logic        fb;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    mem_wb_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_regwrite   (in_regwrite),
        .in_memtoreg   (in_memtoreg),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_read_data  (in_read_data),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .rd            (rd),
        .writedata     (writedata),
        .regwrite      (regwrite),
        .wb_valid      (wb_valid),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of MEM inputs and queue the outputs expected after the next edge.
    task automatic step(input string nm, input logic st, input logic fl, input logic v,
                        input logic rw, input logic m2r, input logic [4:0] r,
                        input logic [31:0] alu, input logic [31:0] rdat,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic ev, input logic [4:0] erd, input logic [31:0] ewd,
                        input logic erw, input logic efa, input logic efb,
                        input logic [31:0] ecnt);
        exp_t e;
        @(negedge clk);
        #1;
        stall = st; flush = fl; in_valid = v; in_regwrite = rw; in_memtoreg = m2r;
        in_rd = r; in_alu_result = alu; in_read_data = rdat; id_rs = rs; id_rt = rt;
        e.name = nm; e.v = ev; e.rd = erd; e.wd = ewd; e.rw = erw;
        e.fa = efa; e.fb = efb; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk({mon_e.name, ".wb_valid"}, 32'(wb_valid), 32'(mon_e.v));
            chk({mon_e.name, ".rd"}, 32'(rd), 32'(mon_e.rd));
            chk({mon_e.name, ".writedata"}, writedata, mon_e.wd);
            chk({mon_e.name, ".regwrite"}, 32'(regwrite), 32'(mon_e.rw));
            chk({mon_e.name, ".fwd_a"}, 32'(fwd_a), 32'(mon_e.fa));
            chk({mon_e.name, ".fwd_b"}, 32'(fwd_b), 32'(mon_e.fb));
            chk({mon_e.name, ".retired_count"}, retired_count, mon_e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        //   name      st fl v rw m2r rd  alu           rdata          rs  rt    v rd  wd            rw fa fb cnt
        step("pre_a",  0, 0, 1, 1, 0, 4,  32'd9,        32'd0,         4,  0,    1, 4, 32'd9,        1, 1, 0, 32'd0);
        step("pre_b",  0, 0, 1, 1, 0, 4,  32'd9,        32'd0,         4,  0,    1, 4, 32'd9,        1, 1, 0, 32'd1);
        drain();

        // Asynchronous reset pulse away from any clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.rd", 32'(rd), 32'd0);
        chk("rst.writedata", writedata, 32'd0);
        chk("rst.regwrite", 32'(regwrite), 32'd0);
        chk("rst.fwd_a", 32'(fwd_a), 32'd0);
        chk("rst.fwd_b", 32'(fwd_b), 32'd0);
        chk("rst.retired_count", retired_count, 32'd0);
        #1 rst = 1'b0;

        step("alu_wr", 0, 0, 1, 1, 0, 1,  32'd5,        32'd0,         1,  2,    1, 1, 32'd5,        1, 1, 0, 32'd0);
        step("idle1",  0, 0, 0, 0, 0, 0,  32'd0,        32'd0,         0,  0,    0, 0, 32'd0,        0, 0, 0, 32'd1);
        step("load",   0, 0, 1, 1, 1, 8,  32'd7,        32'hDEAD_BEEF, 8,  9,    1, 8, 32'hDEAD_BEEF,1, 1, 0, 32'd1);
        step("zero_rd",0, 0, 1, 1, 0, 0,  32'hFFFF_FFFF,32'd0,         0,  0,    1, 0, 32'hFFFF_FFFF,0, 0, 0, 32'd2);
        step("masked", 0, 0, 0, 1, 0, 6,  32'h11,       32'd0,         6,  6,    0, 6, 32'h11,       0, 0, 0, 32'd3);
        step("rd3",    0, 0, 1, 1, 0, 3,  32'h33,       32'd0,         5,  3,    1, 3, 32'h33,       1, 0, 1, 32'd3);
        step("stall1", 1, 0, 1, 1, 0, 7,  32'h77,       32'd0,         5,  3,    1, 3, 32'h33,       1, 0, 1, 32'd3);
        step("stall2", 1, 0, 1, 1, 0, 7,  32'h77,       32'd0,         5,  3,    1, 3, 32'h33,       1, 0, 1, 32'd3);
        step("stall3", 1, 0, 1, 1, 0, 7,  32'h77,       32'd0,         5,  3,    1, 3, 32'h33,       1, 0, 1, 32'd3);
        step("fl_st",  1, 1, 1, 1, 0, 7,  32'h77,       32'd0,         5,  3,    0, 3, 32'h33,       0, 0, 0, 32'd3);
        step("idle2",  0, 0, 0, 0, 0, 0,  32'd0,        32'd0,         0,  0,    0, 0, 32'd0,        0, 0, 0, 32'd3);
        step("rd10",   0, 0, 1, 1, 0, 10, 32'hA0,       32'd0,         10, 0,    1, 10,32'hA0,       1, 1, 0, 32'd3);
        step("flush",  0, 1, 1, 1, 0, 11, 32'hB,        32'd0,         10, 0,    0, 10,32'hA0,       0, 0, 0, 32'd4);
        step("idle3",  0, 0, 0, 0, 0, 0,  32'd0,        32'd0,         0,  0,    0, 0, 32'd0,        0, 0, 0, 32'd4);
        drain();

        // Counter wrap: preload the counter while the latch is empty.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        step("pre_wrap",0,0, 1, 1, 0, 2,  32'd1,        32'd0,         0,  0,    1, 2, 32'd1,        1, 0, 0, 32'hFFFF_FFFF);
        step("wrap",   0, 0, 0, 0, 0, 0,  32'd0,        32'd0,         0,  0,    0, 0, 32'd0,        0, 0, 0, 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
